// File: rtl/grf_wport_arbiter.sv
// grf_wport_arbiter
// Arbitrates the single GRF write port between the W-stage writeback (always
// wins), a small FIFO of secondary long-latency results that drain into idle
// slots, and a wipe sequencer that zeroes registers 1..31. A starvation
// counter raises freeze so a queued secondary result cannot wait forever.
module grf_wport_arbiter #(
    parameter int DEPTH      = 2,   // secondary FIFO entries, power of 2, >= 2
    parameter int STARVE_MAX = 4    // starved cycles before freeze, >= 1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        w_we,
    input  logic [4:0]  w_a3,
    input  logic [31:0] w_wd,
    input  logic        s_valid,
    input  logic [4:0]  s_a3,
    input  logic [31:0] s_wd,
    output logic        s_ready,
    input  logic        wipe_req,
    input  logic [4:0]  rd_a1,
    input  logic [4:0]  rd_a2,
    output logic        pend1,
    output logic        pend2,
    output logic        freeze,
    output logic        busy,
    output logic        grf_we,
    output logic [4:0]  grf_a3,
    output logic [31:0] grf_wd
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] STARVE_TOP = CW'(STARVE_MAX);

    typedef enum logic {
        NORMAL = 1'b0,
        WIPE   = 1'b1
    } state_t;

    state_t        state;
    logic [4:0]    idx;

    // Secondary FIFO storage; live=0 marks a squashed or unoccupied slot.
    logic [4:0]       q_a3 [DEPTH];
    logic [31:0]      q_wd [DEPTH];
    logic [DEPTH-1:0] q_live;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;

    logic [CW-1:0] starve_cnt;
    logic [CW-1:0] starve_next;

    logic prim_grant;
    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic enq;

    // Control decode: who owns the port this cycle and what the FIFO does.
    always_comb begin
        fifo_empty = (count == '0);
        fifo_full  = (count == FULL_CNT);
        prim_grant = (state == NORMAL) && w_we && (w_a3 != 5'd0);
        pop        = (state == NORMAL) && !prim_grant && !fifo_empty;
        s_ready    = (state == NORMAL) && !fifo_full && !clr;
        enq        = s_valid && s_ready && (s_a3 != 5'd0);
        if (!fifo_empty && !pop) begin
            starve_next = (starve_cnt == STARVE_TOP) ? starve_cnt : starve_cnt + 1'b1;
        end else begin
            starve_next = '0;
        end
    end

    // Write port mux: wipe sweep, then primary, then FIFO head.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        grf_we = 1'b0;
        grf_a3 = 5'd0;
        grf_wd = 32'd0;
        if (!clr) begin
            if (state == WIPE) begin
                grf_we = 1'b1;
                grf_a3 = idx;
            end else if (prim_grant) begin
                grf_we = 1'b1;
                grf_a3 = w_a3;
                grf_wd = w_wd;
            end else if (!fifo_empty) begin
                grf_we = q_live[rd_ptr];
                grf_a3 = q_a3[rd_ptr];
                grf_wd = q_wd[rd_ptr];
            end
        end
    end

    // Pending-write hazard flags against the decode-stage read addresses.
    always_comb begin
        pend1 = 1'b0;
        pend2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_live[i] && (q_a3[i] == rd_a1)) pend1 = 1'b1;
            if (q_live[i] && (q_a3[i] == rd_a2)) pend2 = 1'b1;
        end
        if (rd_a1 == 5'd0) pend1 = 1'b0;
        if (rd_a2 == 5'd0) pend2 = 1'b0;
    end

    // FSM, FIFO bookkeeping, starvation counter and registered status outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // read in this block sees the pre-edge value regardless of order.
        if (clr) begin
            // NOTE: only the live bits are reset; FIFO payload is never read
            // while its live bit is clear, so the data arrays need no reset.
            state      <= NORMAL;
            idx        <= 5'd1;
            q_live     <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            freeze     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                NORMAL: begin
                    // A granted primary write supersedes any queued write to the same register.
                    if (prim_grant) begin
                        for (int i = 0; i < DEPTH; i++) begin
                            if (q_a3[i] == w_a3) q_live[i] <= 1'b0;
                        end
                    end
                    if (pop) begin
                        q_live[rd_ptr] <= 1'b0;
                        rd_ptr         <= rd_ptr + 1'b1;
                    end
                    if (enq) begin
                        q_a3[wr_ptr]   <= s_a3;
                        q_wd[wr_ptr]   <= s_wd;
                        q_live[wr_ptr] <= !(prim_grant && (w_a3 == s_a3));
                        wr_ptr         <= wr_ptr + 1'b1;
                    end
                    count      <= count + {{AW{1'b0}}, enq} - {{AW{1'b0}}, pop};
                    starve_cnt <= starve_next;
                    freeze     <= (starve_next == STARVE_TOP);
                    if (wipe_req) begin
                        state      <= WIPE;
                        busy       <= 1'b1;
                        freeze     <= 1'b1;
                        q_live     <= '0;
                        rd_ptr     <= '0;
                        wr_ptr     <= '0;
                        count      <= '0;
                        starve_cnt <= '0;
                    end
                end
                WIPE: begin
                    if (idx == 5'd31) begin
                        state  <= NORMAL;
                        idx    <= 5'd1;
                        busy   <= 1'b0;
                        freeze <= 1'b0;
                    end else begin
                        idx <= idx + 5'd1;
                    end
                end
                default: state <= NORMAL;
            endcase
        end
    end

endmodule

// File: tb/tb_grf_wport_arbiter.sv
// Self-checking bench for grf_wport_arbiter (DEPTH=2, STARVE_MAX=4).
// Each driven cycle pushes its expected port/status values onto a scoreboard
// queue; the entry is popped and compared at the following negedge.
module tb_grf_wport_arbiter;

    logic        clk = 1'b0;
    logic        clr;
    logic        w_we;
    logic [4:0]  w_a3;
    logic [31:0] w_wd;
    logic        s_valid;
    logic [4:0]  s_a3;
    logic [31:0] s_wd;
    logic        s_ready;
    logic        wipe_req;
    logic [4:0]  rd_a1;
    logic [4:0]  rd_a2;
    logic        pend1;
    logic        pend2;
    logic        freeze;
    logic        busy;
    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd;

    grf_wport_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
        .clk      (clk),
        .clr      (clr),
        .w_we     (w_we),
        .w_a3     (w_a3),
        .w_wd     (w_wd),
        .s_valid  (s_valid),
        .s_a3     (s_a3),
        .s_wd     (s_wd),
        .s_ready  (s_ready),
        .wipe_req (wipe_req),
        .rd_a1    (rd_a1),
        .rd_a2    (rd_a2),
        .pend1    (pend1),
        .pend2    (pend2),
        .freeze   (freeze),
        .busy     (busy),
        .grf_we   (grf_we),
        .grf_a3   (grf_a3),
        .grf_wd   (grf_wd)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic        rdy;
        logic        frz;
        logic        bsy;
        logic        p1;
        logic        p2;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (cycle %0d): got %0h want %0h", tag, cyc, act, exp);
        end
    endtask

    function automatic exp_t ex(input logic we, input logic [4:0] a3, input logic [31:0] wd,
                                input logic rdy, input logic frz, input logic bsy,
                                input logic p1, input logic p2);
        exp_t e;
        e.we = we; e.a3 = a3; e.wd = wd; e.rdy = rdy;
        e.frz = frz; e.bsy = bsy; e.p1 = p1; e.p2 = p2;
        return e;
    endfunction

    // Pop one expectation and compare against the settled DUT outputs.
    task automatic observe();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_underflow", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check("grf_we", {31'd0, grf_we}, {31'd0, e.we});
        if (e.we) begin
            check("grf_a3", {27'd0, grf_a3}, {27'd0, e.a3});
            check("grf_wd", grf_wd, e.wd);
        end
        check("s_ready", {31'd0, s_ready}, {31'd0, e.rdy});
        check("freeze",  {31'd0, freeze},  {31'd0, e.frz});
        check("busy",    {31'd0, busy},    {31'd0, e.bsy});
        check("pend1",   {31'd0, pend1},   {31'd0, e.p1});
        check("pend2",   {31'd0, pend2},   {31'd0, e.p2});
    endtask

    // Drive one cycle of stimulus, queue its expectation, check, advance.
    task automatic step(input logic we, input logic [4:0] a3, input logic [31:0] wd,
                        input logic sv, input logic [4:0] sa, input logic [31:0] sd,
                        input logic wp, input logic c, input exp_t e);
        w_we = we; w_a3 = a3; w_wd = wd;
        s_valid = sv; s_a3 = sa; s_wd = sd;
        wipe_req = wp; clr = c;
        sb.push_back(e);
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input exp_t e);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, e);
    endtask

    initial begin
        w_we = 0; w_a3 = 0; w_wd = 0; s_valid = 0; s_a3 = 0; s_wd = 0;
        wipe_req = 0; rd_a1 = 0; rd_a2 = 0; clr = 1'b1;
        @(posedge clk);
        #1;

        // Reset state while clr is held.
        step(0, 0, 0, 1, 5'd3, 32'h9, 0, 1, ex(0, 0, 0, 0, 0, 0, 0, 0));
        step(0, 0, 0, 0, 0, 0, 0, 1, ex(0, 0, 0, 0, 0, 0, 0, 0));

        // Back-to-back primary writes.
        step(1, 5'd5, 32'h11, 0, 0, 0, 0, 0, ex(1, 5'd5, 32'h11, 1, 0, 0, 0, 0));
        step(1, 5'd6, 32'h22, 0, 0, 0, 0, 0, ex(1, 5'd6, 32'h22, 1, 0, 0, 0, 0));

        // Single secondary push drains one cycle later; pend only in between.
        rd_a1 = 5'd7; rd_a2 = 5'd8;
        step(0, 0, 0, 1, 5'd7, 32'hAB, 0, 0, ex(0, 0, 0, 1, 0, 0, 0, 0));
        idle(ex(1, 5'd7, 32'hAB, 1, 0, 0, 1, 0));
        idle(ex(0, 0, 0, 1, 0, 0, 0, 0));
        rd_a1 = 0; rd_a2 = 0;

        // Fill FIFO under continuous primary traffic; starvation forces freeze.
        step(1, 5'd1, 32'h101, 1, 5'd10, 32'hA0, 0, 0, ex(1, 5'd1, 32'h101, 1, 0, 0, 0, 0));
        step(1, 5'd2, 32'h102, 1, 5'd11, 32'hA1, 0, 0, ex(1, 5'd2, 32'h102, 1, 0, 0, 0, 0));
        step(1, 5'd3, 32'h103, 1, 5'd12, 32'hA2, 0, 0, ex(1, 5'd3, 32'h103, 0, 0, 0, 0, 0));
        step(1, 5'd4, 32'h104, 1, 5'd12, 32'hA2, 0, 0, ex(1, 5'd4, 32'h104, 0, 0, 0, 0, 0));
        step(1, 5'd5, 32'h105, 1, 5'd12, 32'hA2, 0, 0, ex(1, 5'd5, 32'h105, 0, 0, 0, 0, 0));
        // Freeze cycle: head pops while full, a concurrent push is refused.
        step(0, 0, 0, 1, 5'd12, 32'hA2, 0, 0, ex(1, 5'd10, 32'hA0, 0, 1, 0, 0, 0));
        idle(ex(1, 5'd11, 32'hA1, 1, 0, 0, 0, 0));
        idle(ex(0, 0, 0, 1, 0, 0, 0, 0));

        // Squash: newer primary write to $9 kills the queued one.
        rd_a1 = 5'd9;
        step(0, 0, 0, 1, 5'd9, 32'h1, 0, 0, ex(0, 0, 0, 1, 0, 0, 0, 0));
        step(1, 5'd9, 32'h2, 0, 0, 0, 0, 0, ex(1, 5'd9, 32'h2, 1, 0, 0, 1, 0));
        idle(ex(0, 0, 0, 1, 0, 0, 0, 0));
        idle(ex(0, 0, 0, 1, 0, 0, 0, 0));
        // Same-cycle squash of an entry pushed alongside the primary write.
        rd_a1 = 5'd13; rd_a2 = 5'd13;
        step(1, 5'd13, 32'h55, 1, 5'd13, 32'h66, 0, 0, ex(1, 5'd13, 32'h55, 1, 0, 0, 0, 0));
        idle(ex(0, 0, 0, 1, 0, 0, 0, 0));
        // Writes to $0 from either source are dropped.
        rd_a1 = 0; rd_a2 = 0;
        step(1, 5'd0, 32'h77, 1, 5'd0, 32'h88, 0, 0, ex(0, 0, 0, 1, 0, 0, 0, 0));
        idle(ex(0, 0, 0, 1, 0, 0, 0, 0));

        // Wipe with one entry queued: entry is flushed, then 31 zero writes.
        rd_a1 = 5'd14;
        step(1, 5'd2, 32'h3, 1, 5'd14, 32'h77, 0, 0, ex(1, 5'd2, 32'h3, 1, 0, 0, 0, 0));
        step(1, 5'd3, 32'h4, 0, 0, 0, 1, 0, ex(1, 5'd3, 32'h4, 1, 0, 0, 1, 0));
        for (int i = 1; i <= 31; i++) begin
            step(0, 0, 0, 1, 5'd4, 32'h5, (i == 5), 0,
                 ex(1, 5'(i), 32'd0, 0, 1, 1, 0, 0));
        end
        idle(ex(0, 0, 0, 1, 0, 0, 0, 0));
        idle(ex(0, 0, 0, 1, 0, 0, 0, 0));
        rd_a1 = 0;

        // clr at idx 10 aborts the wipe.
        step(0, 0, 0, 0, 0, 0, 1, 0, ex(0, 0, 0, 1, 0, 0, 0, 0));
        for (int i = 1; i <= 9; i++) begin
            idle(ex(1, 5'(i), 32'd0, 0, 1, 1, 0, 0));
        end
        step(0, 0, 0, 1, 5'd4, 32'h5, 0, 1, ex(0, 0, 0, 0, 1, 1, 0, 0));
        idle(ex(0, 0, 0, 1, 0, 0, 0, 0));
        // A fresh wipe restarts from register 1.
        step(0, 0, 0, 0, 0, 0, 1, 0, ex(0, 0, 0, 1, 0, 0, 0, 0));
        idle(ex(1, 5'd1, 32'd0, 0, 1, 1, 0, 0));
        idle(ex(1, 5'd2, 32'd0, 0, 1, 1, 0, 0));
        step(0, 0, 0, 0, 0, 0, 0, 1, ex(0, 0, 0, 0, 1, 1, 0, 0));
        step(1, 5'd20, 32'hCAFE, 0, 0, 0, 0, 0, ex(1, 5'd20, 32'hCAFE, 1, 0, 0, 0, 0));

        if (sb.size() != 0) check("scoreboard_leftover", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
